// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
package cla_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of nibble steps needed for a given operand width.
  function automatic int unsigned num_nibbles(input int unsigned width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    // Each carry is expanded from generate/propagate terms, no ripple chain.
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/cla_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble per clock, LSB nibble first.
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N     = num_nibbles(WIDTH);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;

  logic [NIBBLE-1:0]  nib_a;
  logic [NIBBLE-1:0]  nib_b;
  logic [NIBBLE-1:0]  slice_s;
  logic               slice_cout;

  // Operand nibble selected by the current index.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_a = a_q[k*NIBBLE +: NIBBLE];
        nib_b = b_q[k*NIBBLE +: NIBBLE];
      end
    end
  end

  cla4_slice u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int unsigned k = 0; k < N; k++) begin
          if (idx_q == IDX_W'(k)) begin
            sum_d[k*NIBBLE +: NIBBLE] = slice_s;
          end
        end
        carry_d = slice_cout;
        if (idx_q == IDX_W'(N - 1)) begin
          // The top nibble's msb is the final sum msb, so overflow is settled here.
          ovf_d   = (a_msb_q == b_msb_q) && (slice_s[NIBBLE-1] != a_msb_q);
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = IDX_W'(idx_q + 1'b1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Bench for cla_serial_adder at WIDTH=16 and WIDTH=4 with a result scoreboard per instance.
module tb_cla_serial_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        cin16 = 1'b0;
  logic        out_valid16;
  logic        out_ready16 = 1'b0;
  logic [15:0] sum16;
  logic        cout16;
  logic        ovf16;

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        cin4 = 1'b0;
  logic        out_valid4;
  logic        out_ready4 = 1'b0;
  logic [3:0]  sum4;
  logic        cout4;
  logic        ovf4;

  int checks = 0;
  int errors = 0;

  res_t q16[$];
  res_t q4[$];

  always #5 clk = ~clk;

  cla_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  cla_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for a pushed transaction.
  function automatic res_t model16(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] full;
    res_t r;
    full   = {1'b0, x} + {1'b0, y} + 17'(c);
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (x[15] == y[15]) && (full[15] != x[15]);
    return r;
  endfunction

  function automatic res_t model4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] full;
    res_t r;
    full   = {1'b0, x} + {1'b0, y} + 5'(c);
    r.sum  = {12'h000, full[3:0]};
    r.cout = full[4];
    r.ovf  = (x[3] == y[3]) && (full[3] != x[3]);
    return r;
  endfunction

  // Scoreboards: push on acceptance, pop when a result is taken; reset drops in-flight work.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      q16.delete();
      q4.delete();
    end else begin
      if (in_valid16 && in_ready16) q16.push_back(model16(a16, b16, cin16));
      if (out_valid16 && out_ready16) begin
        if (q16.size() == 0) chk("sb16_unexpected_result", 32'd1, 32'd0);
        else begin
          e = q16.pop_front();
          chk("sb16_sum", 32'(sum16), 32'(e.sum));
          chk("sb16_cout", 32'(cout16), 32'(e.cout));
          chk("sb16_ovf", 32'(ovf16), 32'(e.ovf));
        end
      end
      if (in_valid4 && in_ready4) q4.push_back(model4(a4, b4, cin4));
      if (out_valid4 && out_ready4) begin
        if (q4.size() == 0) chk("sb4_unexpected_result", 32'd1, 32'd0);
        else begin
          e = q4.pop_front();
          chk("sb4_sum", 32'(sum4), 32'(e.sum[3:0]));
          chk("sb4_cout", 32'(cout4), 32'(e.cout));
          chk("sb4_ovf", 32'(ovf4), 32'(e.ovf));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 16-bit operation with optional backpressure of 'hold' cycles.
  task automatic op16(input vec_t v, input int hold, input string name);
    int lat;
    in_valid16 = 1'b1;
    a16 = v.a; b16 = v.b; cin16 = v.cin;
    chk({name, "_in_ready"}, 32'(in_ready16), 32'd1);
    step();
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      step();
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd4);
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        in_valid16 = 1'b1;
        a16 = 16'hDEAD; b16 = 16'hBEEF; cin16 = 1'b1;
      end
      step();
      in_valid16 = 1'b0;
      chk({name, "_bp_valid"}, 32'(out_valid16), 32'd1);
      chk({name, "_bp_in_ready"}, 32'(in_ready16), 32'd0);
      chk({name, "_bp_sum"}, 32'(sum16), 32'(v.exp_sum));
    end
    chk({name, "_sum"}, 32'(sum16), 32'(v.exp_sum));
    chk({name, "_cout"}, 32'(cout16), 32'(v.exp_cout));
    chk({name, "_ovf"}, 32'(ovf16), 32'(v.exp_ovf));
    out_ready16 = 1'b1;
    step();
    out_ready16 = 1'b0;
    chk({name, "_idle_ready"}, 32'(in_ready16), 32'd1);
    chk({name, "_idle_valid"}, 32'(out_valid16), 32'd0);
  endtask

  initial begin
    vec_t tbl[7];
    int lat;
    int last;
    int nacc;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[5] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready16), 32'd1);
    chk("rst_out_valid", 32'(out_valid16), 32'd0);
    chk("rst_sum", 32'(sum16), 32'd0);
    chk("rst_cout", 32'(cout16), 32'd0);
    chk("rst_ovf", 32'(ovf16), 32'd0);
    chk("rst_in_ready4", 32'(in_ready4), 32'd1);

    foreach (tbl[i]) op16(tbl[i], 0, $sformatf("vec%0d", i));

    // Backpressure: result held for 5 cycles while a new request is ignored.
    op16(tbl[2], 5, "bp");

    // Reset during the second RUN cycle discards the operation.
    in_valid16 = 1'b1;
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0;
    step();
    in_valid16 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrun_in_ready", 32'(in_ready16), 32'd1);
    chk("midrun_out_valid", 32'(out_valid16), 32'd0);
    chk("midrun_sum", 32'(sum16), 32'd0);
    op16(tbl[4], 0, "post_rst");

    // WIDTH=4 single operation and latency.
    in_valid4 = 1'b1;
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      step();
      lat++;
    end
    chk("w4_latency", 32'(lat), 32'd1);
    chk("w4_sum", 32'(sum4), 32'h0);
    chk("w4_cout", 32'(cout4), 32'd1);
    chk("w4_ovf", 32'(ovf4), 32'd0);
    out_ready4 = 1'b1;
    step();
    chk("w4_idle_ready", 32'(in_ready4), 32'd1);

    // Back-to-back WIDTH=4 traffic: one acceptance every 3 cycles.
    in_valid4 = 1'b1;
    last = -1;
    nacc = 0;
    for (int i = 0; i < 15; i++) begin
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      cin4 = 1'($urandom);
      if (in_ready4) begin
        if (last >= 0) chk("w4_b2b_interval", 32'(i - last), 32'd3);
        last = i;
        nacc++;
      end
      step();
    end
    in_valid4 = 1'b0;
    chk("w4_b2b_count", 32'(nacc), 32'd5);
    for (int i = 0; i < 6; i++) step();
    out_ready4 = 1'b0;

    chk("sb16_drained", 32'(q16.size()), 32'd0);
    chk("sb4_drained", 32'(q4.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
